spi_peripheral: RTL

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

---
 rtl/spi_peripheral.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only peripheral exposing nine 8-bit configuration registers.
// All SPI pins are resynchronized into clk; a register is written only when a frame is exactly 16 bits long.
module spi_peripheral #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h08
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ncs,
    input  logic       copi,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] out_3_0_pwm_gen_channel,
    output logic [7:0] out_7_4_pwm_gen_channel,
    output logic [7:0] pwm_gen_0_ch_0_duty,
    output logic [7:0] pwm_gen_0_ch_1_duty,
    output logic [7:0] pwm_gen_1_ch_0_duty,
    output logic [7:0] pwm_gen_1_ch_1_duty,
    output logic [7:0] pwm_gen_1_0_freq_div
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] ncs_sync_r;
    logic [SYNC_STAGES-1:0] copi_sync_r;
    logic                   sclk_prev_r;
    logic                   ncs_prev_r;
    logic                   sclk_s;
    logic                   ncs_s;
    logic                   copi_s;
    logic                   sclk_rise_s;
    logic                   ncs_rise_s;
    logic                   ncs_fall_s;
    logic                   frame_ok_s;

    state_t      state_r, state_nx;
    logic [4:0]  bit_cnt_r, cnt_nx;
    logic [15:0] shift_r, shift_nx;
    logic        wr_pend_r, wr_pend_nx;
    logic [6:0]  wr_addr_r, wr_addr_nx;
    logic [7:0]  wr_data_r, wr_data_nx;

    logic [7:0] reg_out_r;
    logic [7:0] reg_pwm_r;
    logic [7:0] reg_ch30_r;
    logic [7:0] reg_ch74_r;
    logic [7:0] reg_d00_r;
    logic [7:0] reg_d01_r;
    logic [7:0] reg_d10_r;
    logic [7:0] reg_d11_r;
    logic [7:0] reg_div_r;

    // Pin synchronizers; ncs resets low so a chip select held low through reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_r <= '0;
            ncs_sync_r  <= '0;
            copi_sync_r <= '0;
            sclk_prev_r <= 1'b0;
            ncs_prev_r  <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
            ncs_sync_r  <= {ncs_sync_r[SYNC_STAGES-2:0], ncs};
            copi_sync_r <= {copi_sync_r[SYNC_STAGES-2:0], copi};
            sclk_prev_r <= sclk_s;
            ncs_prev_r  <= ncs_s;
        end
    end

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign ncs_s       = ncs_sync_r[SYNC_STAGES-1];
    assign copi_s      = copi_sync_r[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_r;
    assign ncs_rise_s  = ncs_s & ~ncs_prev_r;
    assign ncs_fall_s  = ~ncs_s & ncs_prev_r;
    assign frame_ok_s  = (bit_cnt_r == 5'd16) && shift_r[15] && (shift_r[14:8] <= MAX_ADDR);

    // Frame FSM state, shift path and the one-cycle write request staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= 5'd0;
            shift_r   <= 16'h0000;
            wr_pend_r <= 1'b0;
            wr_addr_r <= 7'h00;
            wr_data_r <= 8'h00;
        end else begin
            state_r   <= state_nx;
            bit_cnt_r <= cnt_nx;
            shift_r   <= shift_nx;
            wr_pend_r <= wr_pend_nx;
            wr_addr_r <= wr_addr_nx;
            wr_data_r <= wr_data_nx;
        end
    end

    // Next-state logic; an ncs rising edge wins over a coincident sclk edge.
    always_comb begin
        state_nx   = state_r;
        cnt_nx     = bit_cnt_r;
        shift_nx   = shift_r;
        wr_pend_nx = 1'b0;
        wr_addr_nx = wr_addr_r;
        wr_data_nx = wr_data_r;
        case (state_r)
            IDLE: begin
                if (ncs_fall_s) begin
                    state_nx = SHIFT;
                    cnt_nx   = 5'd0;
                    shift_nx = 16'h0000;
                end else begin
                    state_nx = IDLE;
                end
            end
            SHIFT: begin
                if (ncs_rise_s) begin
                    state_nx = IDLE;
                    if (frame_ok_s) begin
                        wr_pend_nx = 1'b1;
                        wr_addr_nx = shift_r[14:8];
                        wr_data_nx = shift_r[7:0];
                    end else begin
                        wr_pend_nx = 1'b0;
                    end
                end else if (sclk_rise_s) begin
                    shift_nx = {shift_r[14:0], copi_s};
                    if (bit_cnt_r == 5'd17) begin
                        cnt_nx = bit_cnt_r;
                    end else begin
                        cnt_nx = bit_cnt_r + 5'd1;
                    end
                end else begin
                    state_nx = SHIFT;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Register file: exactly one location loads per accepted frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_out_r  <= 8'h00;
            reg_pwm_r  <= 8'h00;
            reg_ch30_r <= 8'h00;
            reg_ch74_r <= 8'h00;
            reg_d00_r  <= 8'h00;
            reg_d01_r  <= 8'h00;
            reg_d10_r  <= 8'h00;
            reg_d11_r  <= 8'h00;
            reg_div_r  <= 8'h00;
        end else if (wr_pend_r) begin
            case (wr_addr_r)
                7'h00:   reg_out_r  <= wr_data_r;
                7'h01:   reg_pwm_r  <= wr_data_r;
                7'h02:   reg_ch30_r <= wr_data_r;
                7'h03:   reg_ch74_r <= wr_data_r;
                7'h04:   reg_d00_r  <= wr_data_r;
                7'h05:   reg_d01_r  <= wr_data_r;
                7'h06:   reg_d10_r  <= wr_data_r;
                7'h07:   reg_d11_r  <= wr_data_r;
                7'h08:   reg_div_r  <= wr_data_r;
                default: reg_out_r  <= reg_out_r;
            endcase
        end
    end

    assign en_reg_out_7_0          = reg_out_r;
    assign en_reg_pwm_7_0          = reg_pwm_r;
    assign out_3_0_pwm_gen_channel = reg_ch30_r;
    assign out_7_4_pwm_gen_channel = reg_ch74_r;
    assign pwm_gen_0_ch_0_duty     = reg_d00_r;
    assign pwm_gen_0_ch_1_duty     = reg_d01_r;
    assign pwm_gen_1_ch_0_duty     = reg_d10_r;
    assign pwm_gen_1_ch_1_duty     = reg_d11_r;
    assign pwm_gen_1_0_freq_div    = reg_div_r;

endmodule
